// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional-N baud generator producing oversample and bit ticks
module baud_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick_ovs,
  output logic              tick_bit,
  output logic              clk_out,
  output logic              load_ack,
  output logic              div_err
);

  localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

  logic [DIV_W-1:0]  r_act_int;
  logic [DIV_W-1:0]  r_pend_int;
  logic [DIV_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_act_frac;
  logic [FRAC_W-1:0] r_pend_frac;
  logic [FRAC_W-1:0] r_acc;
  logic              r_c;
  logic              r_pend_valid;
  logic [OVS_W-1:0]  r_ovs_cnt;

  logic [DIV_W:0]    w_period;
  logic [DIV_W:0]    w_nxt_period;
  logic              w_wrap;
  logic              w_load_ok;
  logic              w_apply_slot;
  logic              w_apply_new;
  logic              w_apply_pend;
  logic [FRAC_W:0]   w_acc_sum;
  logic [DIV_W-1:0]  w_nxt_int;
  logic [FRAC_W-1:0] w_nxt_frac;
  logic [DIV_W-1:0]  w_nxt_cnt;
  logic [FRAC_W-1:0] w_nxt_acc;
  logic              w_nxt_c;
  logic              w_nxt_clk;

  // Period is one bit wider than the divisor so act_int = 2^DIV_W-1 plus carry cannot overflow.
  assign w_period  = {1'b0, r_act_int} + {{DIV_W{1'b0}}, r_c};
  assign w_wrap    = en && ({1'b0, r_cnt} == (w_period - (DIV_W+1)'(1)));
  assign w_load_ok = load && (div_int >= DIV_W'(2));
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_act_frac};

  // A new divisor may only take effect at a period boundary or while idle.
  assign w_apply_slot = !en || w_wrap;
  assign w_apply_new  = w_apply_slot && w_load_ok;
  assign w_apply_pend = w_apply_slot && !w_load_ok && r_pend_valid;

  always_comb begin
    w_nxt_int  = r_act_int;
    w_nxt_frac = r_act_frac;
    w_nxt_cnt  = r_cnt + DIV_W'(1);
    w_nxt_acc  = r_acc;
    w_nxt_c    = r_c;
    if (w_apply_new) begin
      w_nxt_int  = div_int;
      w_nxt_frac = div_frac;
    end else if (w_apply_pend) begin
      w_nxt_int  = r_pend_int;
      w_nxt_frac = r_pend_frac;
    end
    if (!en) begin
      w_nxt_cnt = '0;
      w_nxt_acc = '0;
      w_nxt_c   = 1'b0;
    end else if (w_wrap) begin
      w_nxt_cnt = '0;
      if (w_apply_new || w_apply_pend) begin
        w_nxt_acc = '0;
        w_nxt_c   = 1'b0;
      end else begin
        {w_nxt_c, w_nxt_acc} = w_acc_sum;
      end
    end
  end

  assign w_nxt_period = {1'b0, w_nxt_int} + {{DIV_W{1'b0}}, w_nxt_c};
  assign w_nxt_clk    = en && ({1'b0, w_nxt_cnt} < (w_nxt_period >> 1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_act_int    <= DIV_W'(2);
      r_act_frac   <= '0;
      r_pend_int   <= '0;
      r_pend_frac  <= '0;
      r_pend_valid <= 1'b0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_c          <= 1'b0;
      r_ovs_cnt    <= '0;
      tick_ovs     <= 1'b0;
      tick_bit     <= 1'b0;
      clk_out      <= 1'b0;
      load_ack     <= 1'b0;
      div_err      <= 1'b0;
    end else begin
      r_act_int  <= w_nxt_int;
      r_act_frac <= w_nxt_frac;
      r_cnt      <= w_nxt_cnt;
      r_acc      <= w_nxt_acc;
      r_c        <= w_nxt_c;
      if (w_apply_new || w_apply_pend) begin
        r_pend_valid <= 1'b0;
      end else if (w_load_ok) begin
        r_pend_valid <= 1'b1;
        r_pend_int   <= div_int;
        r_pend_frac  <= div_frac;
      end
      if (!en) begin
        r_ovs_cnt <= '0;
      end else if (w_wrap) begin
        r_ovs_cnt <= (r_ovs_cnt == OVS_LAST) ? '0 : r_ovs_cnt + OVS_W'(1);
      end
      tick_ovs <= w_wrap;
      tick_bit <= w_wrap && (r_ovs_cnt == OVS_LAST);
      clk_out  <= w_nxt_clk;
      load_ack <= w_apply_new || w_apply_pend;
      div_err  <= load && !w_load_ok;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - directed self-checking bench for baud_gen_frac
module tb_baud_gen_frac;

  logic        clk_sys;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        tick_ovs;
  logic        tick_bit;
  logic        clk_out;
  logic        load_ack;
  logic        div_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ack   = 0;
  int n_err   = 0;

  baud_gen_frac #(.DIV_W(16), .FRAC_W(4), .OVS(16)) u_dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .div_int  (div_int),
    .div_frac (div_frac),
    .tick_ovs (tick_ovs),
    .tick_bit (tick_bit),
    .clk_out  (clk_out),
    .load_ack (load_ack),
    .div_err  (div_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (load_ack) n_ack++;
    if (div_err) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_ovs && n < 2000);
  endtask

  task automatic wait_bit(output int n, output int novs);
    n = 0;
    novs = 0;
    do begin
      step();
      n++;
      if (tick_ovs) novs++;
    end while (!tick_bit && n < 5000);
  endtask

  task automatic idle_load(input logic [15:0] di, input logic [3:0] df);
    en = 1'b0;
    step();
    load = 1'b1;
    div_int = di;
    div_frac = df;
    step();
    load = 1'b0;
  endtask

  int n;
  int novs;
  int a0;
  int e0;
  logic [3:0] pat;
  int exp_iv [5] = '{3, 3, 4, 3, 4};

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    load = 1'b0;
    div_int = '0;
    div_frac = '0;
    steps(2);
    check("reset_outs", {tick_ovs, tick_bit, clk_out, load_ack, div_err}, 0);
    rst_n = 1'b1;
    step();

    // Integer divisor 4 loaded while idle
    load = 1'b1;
    div_int = 16'd4;
    div_frac = 4'd0;
    step();
    check("ack_idle", load_ack, 1);
    load = 1'b0;
    step();
    check("ack_single", load_ack, 0);
    en = 1'b1;
    wait_tick(n);
    check("first_tick_p4", n, 4);
    pat[3] = clk_out; step();
    pat[2] = clk_out; step();
    pat[1] = clk_out; step();
    pat[0] = clk_out;
    check("clk_pattern", pat, 4'b1100);
    wait_tick(n);
    wait_tick(n);
    check("interval_p4", n, 4);

    // Fractional divisor 3.5
    idle_load(16'd3, 4'd8);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_tick(n);
      check($sformatf("frac_iv%0d", i), n, exp_iv[i]);
    end
    wait_bit(n, novs);
    wait_bit(n, novs);
    check("bit_cycles", n, 56);
    check("ovs_per_bit", novs, 16);

    // Rejected load while running
    idle_load(16'd5, 4'd0);
    en = 1'b1;
    wait_tick(n);
    check("first_tick_p5", n, 5);
    steps(2);
    a0 = n_ack;
    e0 = n_err;
    load = 1'b1;
    div_int = 16'd1;
    step();
    check("err_pulse", div_err, 1);
    load = 1'b0;
    step();
    check("err_clear", div_err, 0);
    wait_tick(n);
    check("err_rest", n, 1);
    wait_tick(n);
    check("err_iv", n, 5);
    check("err_count", n_err - e0, 1);
    check("err_no_ack", n_ack - a0, 0);

    // Pending overwrite: P=10, load 6 at cnt=3 then 8 at cnt=5
    idle_load(16'd10, 4'd0);
    en = 1'b1;
    wait_tick(n);
    a0 = n_ack;
    steps(3);
    load = 1'b1;
    div_int = 16'd6;
    step();
    load = 1'b0;
    step();
    load = 1'b1;
    div_int = 16'd8;
    step();
    load = 1'b0;
    wait_tick(n);
    check("pend_rest", n, 4);
    check("pend_ack_at_tick", load_ack, 1);
    wait_tick(n);
    check("pend_iv1", n, 8);
    check("pend_ack_once", n_ack - a0, 1);
    wait_tick(n);
    check("pend_iv2", n, 8);

    // Load coinciding with a wrap
    steps(7);
    load = 1'b1;
    div_int = 16'd5;
    step();
    load = 1'b0;
    check("wrap_load_tick", tick_ovs, 1);
    check("wrap_load_ack", load_ack, 1);
    wait_tick(n);
    check("wrap_load_iv", n, 5);

    // Enable falls with a pending divisor
    step();
    load = 1'b1;
    div_int = 16'd7;
    step();
    load = 1'b0;
    en = 1'b0;
    step();
    check("en_fall_ack", load_ack, 1);
    en = 1'b1;
    wait_tick(n);
    check("en_fall_iv", n, 7);

    // Asynchronous reset with a pending divisor
    step();
    load = 1'b1;
    div_int = 16'd9;
    step();
    load = 1'b0;
    check("pre_rst_clk", clk_out, 1);
    a0 = n_ack;
    #2 rst_n = 1'b0;
    #1 check("async_rst_outs", {tick_ovs, tick_bit, clk_out, load_ack, div_err}, 0);
    en = 1'b0;
    steps(2);
    rst_n = 1'b1;
    step();
    en = 1'b1;
    wait_tick(n);
    check("rst_first_tick", n, 2);
    wait_tick(n);
    check("rst_iv", n, 2);
    check("rst_no_ack", n_ack - a0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter DIV_W, default 16: width of the integer divisor.
REQ-002 Parameter FRAC_W, default 4: width of the fractional divisor; the accumulator has the same width.
REQ-003 Parameter OVS, default 16: number of oversample ticks per bit tick; legal values are 1 to 256.
REQ-004 clk_sys  in  1  system clock; every register updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  generator enable; while low the generator is held idle.
REQ-007 load  in  1  one-cycle strobe that requests a new divisor.
REQ-008 div_int  in  DIV_W  integer divisor, sampled when load=1; legal values are 2 or more.
REQ-009 div_frac  in  FRAC_W  fractional divisor in units of 1/2^FRAC_W, sampled when load=1.
REQ-010 tick_ovs  out  1  registered one-cycle pulse marking each oversample period.
REQ-011 tick_bit  out  1  registered one-cycle pulse on every OVS-th tick_ovs.
REQ-012 clk_out  out  1  registered square wave with one cycle per oversample period.
REQ-013 load_ack  out  1  registered one-cycle pulse when a requested divisor takes effect.
REQ-014 div_err  out  1  registered one-cycle pulse when a load is rejected.

Function
REQ-015 Active divisor: registers act_int and act_frac, a pending register, and a pend_valid flag.
REQ-016 Period P = act_int + c, where c is the carry of the accumulator; P is DIV_W+1 bits wide, so the largest value, 2^DIV_W, must not overflow.
REQ-017 Counter cnt (DIV_W bits) while en=1:
- increments by 1 on each clock;
- on the edge where cnt == P-1 ("wrap"), cnt becomes 0 and tick_ovs=1 for the next cycle; otherwise tick_ovs=0.
REQ-018 Accumulator update at each wrap: {c, acc} <= acc + act_frac; the new c sets P for the next period.
REQ-019 Example with act_int=3, act_frac=8, FRAC_W=4: successive periods are 3,3,4,3,4,... cycles, an average of 3.5.
REQ-020 ovs_cnt counts 0..OVS-1 and advances by 1 at each wrap. tick_bit=1 together with tick_ovs on the wrap where ovs_cnt == OVS-1, then ovs_cnt becomes 0. With OVS=1, tick_bit equals tick_ovs.
REQ-021 clk_out next value = 1 when next cnt < floor(P/2), else 0. Example: P=4 gives 2 cycles high, 2 cycles low; P=5 gives 2 high, 3 low.
REQ-022 Idle (en=0): cnt=0, acc=0, c=0, ovs_cnt=0, and tick_ovs, tick_bit and clk_out are 0 on the next edge. When en rises, the first period uses P=act_int, so the first tick_ovs appears P cycles after the first edge with en=1.
REQ-023 Load validation: when load=1 and div_int<2, the load is rejected.
- div_err=1 on the next cycle;
- the active divisor, pending register and load_ack are unchanged.
REQ-024 Valid load with en=0: act_int and act_frac are updated on the next edge and load_ack=1 on the next cycle.
REQ-025 Valid load with en=1 and no wrap in the same cycle: the value goes to pending with pend_valid=1, and the current period completes unchanged.
REQ-026 Valid load in the same cycle as a wrap: the new value applies directly at that wrap.
REQ-027 When a pending divisor is applied at a wrap:
- act is updated, acc=0 and c=0, so the next P equals the new div_int;
- pend_valid=0;
- load_ack=1 together with that tick_ovs.
REQ-028 A second valid load while pend_valid=1 overwrites the pending value; only one load_ack is produced, when the final value is applied.
REQ-029 If en falls while pend_valid=1, the pending value is applied on that edge and load_ack=1 on the next cycle.
REQ-030 Applying a new divisor does not change ovs_cnt.

Reset
REQ-031 rst_n=0 asynchronously clears cnt, acc, c, ovs_cnt, pend_valid and all outputs to 0.
REQ-032 Reset sets act_int=2 and act_frac=0.
REQ-033 Reset in the middle of a period discards any pending divisor and does not produce load_ack.
REQ-034 Generation restarts as from idle, per REQ-022.

Verification
REQ-035 Reset; load div_int=4, frac=0 with en=0; raise en.
-> load_ack 1 cycle after load; tick_ovs every 4 cycles, first one 4 cycles after en; clk_out pattern 1100.
REQ-036 div_int=3, frac=8, FRAC_W=4, OVS=16.
-> tick_ovs intervals 3,3,4,3,4,...; tick_bit interval average 56 cycles; 16 tick_ovs per tick_bit.
REQ-037 Load div_int=1 while running.
-> div_err pulses once; tick_ovs intervals unchanged; no load_ack.
REQ-038 While running with P=10, load 6 at cnt=3, then load 8 at cnt=5.
-> period completes at 10; single load_ack with that tick_ovs; following intervals are 8.
REQ-039 Load in the same cycle as a wrap.
-> next interval equals the new div_int; load_ack appears with that wrap.
REQ-040 Assert rst_n low mid-period with pend_valid=1.
-> all outputs 0 immediately; after release, act_int=2, no load_ack, first tick_ovs 2 cycles after en.
